// File: rtl/fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO: pointer increment,
// occupancy-to-flag decode and read-mode constants.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Increment a pointer of abits+1 bits; the extra MSB acts as the wrap bit.
  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int unsigned abits);
    logic [31:0] mask;
    mask = (32'd1 << (abits + 1)) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

  function automatic fifo_flags_t decode_flags(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned af_level,
                                               input int unsigned ae_level);
    fifo_flags_t f;
    f.full         = (cnt == depth);
    f.empty        = (cnt == 0);
    f.almost_full  = (cnt >= af_level);
    f.almost_empty = (cnt <= ae_level);
    return f;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 16,
  parameter int unsigned ABITS = $clog2(ASIZE)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [ASIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synchronous_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush and
// overflow/underflow pulses; read port is registered or first-word-fall-through.
module synchronous_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned ASIZE    = 16,
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned ABITS    = $clog2(ASIZE),
  parameter int unsigned FWFT     = FIFO_STD,
  parameter int unsigned AF_LEVEL = ASIZE - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [DSIZE-1:0] din,
  input  logic             rd_en,
  output logic [DSIZE-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ABITS:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = ABITS + 1;

  logic [ABITS:0]   wr_ptr_q, wr_ptr_d;
  logic [ABITS:0]   rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic             wr_go, rd_go;
  logic [DSIZE-1:0] mem_rdata;
  fifo_flags_t      flags;

  assign flags = decode_flags(32'(count_q), ASIZE, AF_LEVEL, AE_LEVEL);

  // A write at full is still taken when a read frees a slot on the same edge.
  always_comb begin
    rd_acc = rd_en & ~flags.empty;
    wr_acc = wr_en & (~flags.full | rd_acc);
    wr_go  = wr_acc & ~clear;
    rd_go  = rd_acc & ~clear;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_go) begin
        wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), ABITS));
      end
      if (rd_go) begin
        rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), ABITS));
      end
      count_d     = count_q + PW'(wr_go) - PW'(rd_go);
      overflow_d  = wr_en & ~wr_acc;
      underflow_d = rd_en & ~rd_acc;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .ABITS (ABITS)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_go),
    .waddr_i (wr_ptr_q[ABITS-1:0]),
    .wdata_i (din),
    .raddr_i (rd_ptr_q[ABITS-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign dout = flags.empty ? '0 : mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] dout_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        dout_q <= '0;
      end else if (clear) begin
        dout_q <= '0;
      end else if (rd_go) begin
        dout_q <= mem_rdata;
      end
    end

    assign dout = dout_q;
  end

  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_synchronous_fifo_flags.sv
// Directed bench for synchronous_fifo_flags: registered-read instance checked
// against a queue scoreboard, plus a first-word-fall-through instance.
module tb_synchronous_fifo_flags;

  logic       clk;
  logic       rstn;

  logic       s_clear, s_wr_en, s_rd_en;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic [4:0] s_count;

  logic       f_clear, f_wr_en, f_rd_en;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  int         m_count = 0;
  logic [7:0] e_dout  = 8'h00;
  logic       e_ovf   = 1'b0;
  logic       e_unf   = 1'b0;

  synchronous_fifo_flags #(
    .ASIZE (16),
    .DSIZE (8),
    .FWFT  (0)
  ) u_std (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (s_clear),
    .wr_en        (s_wr_en),
    .din          (s_din),
    .rd_en        (s_rd_en),
    .dout         (s_dout),
    .full         (s_full),
    .empty        (s_empty),
    .almost_full  (s_afull),
    .almost_empty (s_aempty),
    .count        (s_count),
    .overflow     (s_ovf),
    .underflow    (s_unf)
  );

  synchronous_fifo_flags #(
    .ASIZE (16),
    .DSIZE (8),
    .FWFT  (1)
  ) u_fwft (
    .clk          (clk),
    .rstn         (rstn),
    .clear        (f_clear),
    .wr_en        (f_wr_en),
    .din          (f_din),
    .rd_en        (f_rd_en),
    .dout         (f_dout),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_afull),
    .almost_empty (f_aempty),
    .count        (f_count),
    .overflow     (f_ovf),
    .underflow    (f_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_std(input string tag);
    chk({tag, ".count"}, 32'(s_count), 32'(m_count));
    chk({tag, ".full"}, 32'(s_full), 32'(m_count == 16));
    chk({tag, ".empty"}, 32'(s_empty), 32'(m_count == 0));
    chk({tag, ".afull"}, 32'(s_afull), 32'(m_count >= 14));
    chk({tag, ".aempty"}, 32'(s_aempty), 32'(m_count <= 2));
    chk({tag, ".ovf"}, 32'(s_ovf), 32'(e_ovf));
    chk({tag, ".unf"}, 32'(s_unf), 32'(e_unf));
    chk({tag, ".dout"}, 32'(s_dout), 32'(e_dout));
  endtask

  // Drive one cycle on the registered-read instance and update the model.
  task automatic step(input string tag, input logic we, input logic [7:0] d,
                      input logic re, input logic clr);
    logic ra, wa;
    s_wr_en = we;
    s_din   = d;
    s_rd_en = re;
    s_clear = clr;
    if (clr) begin
      exp_q.delete();
      m_count = 0;
      e_dout  = 8'h00;
      e_ovf   = 1'b0;
      e_unf   = 1'b0;
    end else begin
      ra = re && (m_count > 0);
      wa = we && ((m_count < 16) || ra);
      if (ra) e_dout = exp_q.pop_front();
      if (wa) exp_q.push_back(d);
      m_count = m_count + int'(wa) - int'(ra);
      e_ovf   = we & ~wa;
      e_unf   = re & ~ra;
    end
    @(posedge clk);
    #1;
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    s_clear = 1'b0;
    check_std(tag);
  endtask

  initial begin
    rstn    = 1'b0;
    s_clear = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_din = 8'h00;
    f_clear = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = 8'h00;
    #2;
    check_std("reset");
    chk("reset.fwft_dout", 32'(f_dout), 32'h0);
    chk("reset.fwft_empty", 32'(f_empty), 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Fill, then one write too many.
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    step("fill_ovf", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain, then one read too many; dout must hold the last word.
    for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drain_unf", 1'b0, 8'h00, 1'b1, 1'b0);
    step("unf_clear", 1'b0, 8'h00, 1'b0, 1'b0);

    // Simultaneous read and write while full.
    for (int i = 0; i < 16; i++) step("refill", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step("full_rdwr", 1'b1, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Bursts that cross the index wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) step("wrap_wr", 1'b1, 8'(8'h40 + 16 * r + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Read while empty with a concurrent write: write lands, read is dropped.
    step("empty_rdwr", 1'b1, 8'h77, 1'b1, 1'b0);
    step("empty_rdwr_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // First-word-fall-through instance.
    f_wr_en = 1'b1;
    f_din   = 8'h55;
    @(posedge clk);
    #1;
    f_wr_en = 1'b0;
    chk("fwft.dout_after_wr", 32'(f_dout), 32'h55);
    chk("fwft.empty_after_wr", 32'(f_empty), 32'h0);
    chk("fwft.count_after_wr", 32'(f_count), 32'h1);
    @(posedge clk);
    #1;
    chk("fwft.dout_hold", 32'(f_dout), 32'h55);
    f_rd_en = 1'b1;
    @(posedge clk);
    #1;
    f_rd_en = 1'b0;
    chk("fwft.empty_after_pop", 32'(f_empty), 32'h1);
    chk("fwft.dout_after_pop", 32'(f_dout), 32'h0);
    chk("fwft.unf_after_pop", 32'(f_unf), 32'h0);

    // Flush with five words and a concurrent write.
    for (int i = 0; i < 5; i++) step("pre_clear", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step("pre_clear_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clear", 1'b1, 8'hEE, 1'b0, 1'b1);
    step("post_clear", 1'b1, 8'h91, 1'b0, 1'b0);
    step("post_clear_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a burst, away from any edge.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step("pre_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    s_wr_en = 1'b1;
    s_din   = 8'h99;
    #2;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    m_count = 0;
    e_dout  = 8'h00;
    e_ovf   = 1'b0;
    e_unf   = 1'b0;
    check_std("async_rst");
    s_wr_en = 1'b0;
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_std("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
